// File: rtl/mul_interleave.sv
// Interleaved multiplier: N_LANES independent lanes fed round-robin by a dispatch
// pointer and drained in the same order by a collect pointer, so results stay in order.
module mul_interleave #(
    parameter int W        = 15,
    parameter int N_LANES  = 2,
    parameter int LANE_LAT = 2,
    parameter int SIGNED   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   in_a,
    input  logic [W-1:0]                   in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*W-1:0]                 out_data,
    output logic [$clog2(N_LANES+1)-1:0]   occupancy,
    output logic                           busy
);

    localparam int PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int CW = $clog2(LANE_LAT + 1);
    localparam int OW = $clog2(N_LANES + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lane_state_t;

    lane_state_t    state [N_LANES];
    logic [2*W-1:0] data  [N_LANES];
    logic [CW-1:0]  cnt   [N_LANES];
    logic [PW-1:0]  dp;
    logic [PW-1:0]  cp;
    logic           accept;
    logic           pop;

    // The data register holds {a, b} while BUSY and is overwritten by the product.
    function automatic logic [2*W-1:0] product(input logic [2*W-1:0] ops);
        logic [2*W-1:0] a_ext;
        logic [2*W-1:0] b_ext;
        if (SIGNED != 0) begin
            a_ext = {{W{ops[2*W-1]}}, ops[2*W-1:W]};
            b_ext = {{W{ops[W-1]}}, ops[W-1:0]};
        end else begin
            a_ext = {{W{1'b0}}, ops[2*W-1:W]};
            b_ext = {{W{1'b0}}, ops[W-1:0]};
        end
        return a_ext * b_ext;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(N_LANES - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        in_ready  = rst_n && !clr && (state[dp] == IDLE);
        out_valid = !clr && (state[cp] == DONE);
        out_data  = out_valid ? data[cp] : '0;
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
        busy      = (occupancy != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp        <= '0;
            cp        <= '0;
            occupancy <= '0;
            for (int unsigned i = 0; i < N_LANES; i++) begin
                state[i] <= IDLE;
                data[i]  <= '0;
                cnt[i]   <= '0;
            end
        end else if (clr) begin
            dp        <= '0;
            cp        <= '0;
            occupancy <= '0;
            for (int unsigned i = 0; i < N_LANES; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            if (accept) dp <= next_ptr(dp);
            if (pop)    cp <= next_ptr(cp);

            if (accept && !pop)      occupancy <= occupancy + OW'(1);
            else if (pop && !accept) occupancy <= occupancy - OW'(1);

            // A DONE lane only returns to IDLE here, so it cannot be re-filled on its pop edge.
            for (int unsigned i = 0; i < N_LANES; i++) begin
                case (state[i])
                    IDLE: begin
                        if (accept && dp == PW'(i)) begin
                            state[i] <= BUSY;
                            data[i]  <= {in_a, in_b};
                            cnt[i]   <= CW'(LANE_LAT - 1);
                        end
                    end
                    BUSY: begin
                        if (cnt[i] == '0) begin
                            state[i] <= DONE;
                            data[i]  <= product(data[i]);
                        end else begin
                            cnt[i] <= cnt[i] - CW'(1);
                        end
                    end
                    DONE: begin
                        if (pop && cp == PW'(i)) state[i] <= IDLE;
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_interleave.sv
// Randomized check of two mul_interleave instances (unsigned 2x2, signed 1x3) against a
// transaction-level scoreboard: in-order queue of products tagged with their ready cycle.
`timescale 1ns/1ps
module tb_mul_interleave;

    localparam int W    = 15;
    localparam int NL0  = 2;
    localparam int LAT0 = 2;
    localparam int NL1  = 1;
    localparam int LAT1 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    logic           iv   [2];
    logic           ir   [2];
    logic           ov   [2];
    logic           ordy [2];
    logic           bz   [2];
    logic [W-1:0]   a    [2];
    logic [W-1:0]   b    [2];
    logic [2*W-1:0] od   [2];
    logic [1:0]     occ0;
    logic [0:0]     occ1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             rdy;
    } exp_t;

    exp_t           sb     [2][$];
    logic [2*W-1:0] popped [2][$];

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    mul_interleave #(.W(W), .N_LANES(NL0), .LANE_LAT(LAT0), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_a(a[0]), .in_b(b[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(occ0), .busy(bz[0])
    );

    mul_interleave #(.W(W), .N_LANES(NL1), .LANE_LAT(LAT1), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_a(a[1]), .in_b(b[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(occ1), .busy(bz[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int nl_of(input int k);
        return (k == 0) ? NL0 : NL1;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [63:0] occ_of(input int k);
        return (k == 0) ? 64'(occ0) : 64'(occ1);
    endfunction

    // Plain integer multiply; instance 1 interprets operands as two's complement.
    function automatic logic [2*W-1:0] ref_prod(input int k, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint p;
        sx = longint'(x);
        sy = longint'(y);
        if (k == 1 && x[W-1]) sx = sx - (longint'(1) << W);
        if (k == 1 && y[W-1]) sy = sy - (longint'(1) << W);
        p = sx * sy;
        return p[2*W-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                int   n;
                logic hv;
                n  = sb[k].size();
                hv = 1'b0;
                if (n > 0) hv = (sb[k][0].rdy <= cyc);
                hv = hv && !clr;
                check($sformatf("in_ready[%0d]", k), 64'(ir[k]), 64'(!clr && n < nl_of(k)));
                check($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(hv));
                check($sformatf("out_data[%0d]", k), 64'(od[k]), 64'(hv ? sb[k][0].prod : '0));
                check($sformatf("occupancy[%0d]", k), occ_of(k), 64'(n));
                check($sformatf("busy[%0d]", k), 64'(bz[k]), 64'(n != 0));
                if (clr) begin
                    sb[k].delete();
                end else begin
                    if (hv && ordy[k]) begin
                        popped[k].push_back(od[k]);
                        void'(sb[k].pop_front());
                    end
                    if (iv[k] && n < nl_of(k))
                        sb[k].push_back('{ref_prod(k, a[k], b[k]), cyc + 1 + lat_of(k)});
                end
            end
        end
    end

    task automatic offer(input int k, input logic [W-1:0] x, input logic [W-1:0] y);
        logic acc;
        acc   = 1'b0;
        iv[k] = 1'b1;
        a[k]  = x;
        b[k]  = y;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = ir[k];
            @(posedge clk);
            #1;
        end
        iv[k] = 1'b0;
        if (!acc) check($sformatf("offer_timeout[%0d]", k), 64'(0), 64'(1));
    endtask

    task automatic wait_pops(input int k, input int n);
        for (int i = 0; i < 40 && popped[k].size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("pop_count[%0d]", k), 64'(popped[k].size()), 64'(n));
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_in_ready[%0d]", tag, k), 64'(ir[k]), 64'(0));
            check($sformatf("%s_out_valid[%0d]", tag, k), 64'(ov[k]), 64'(0));
            check($sformatf("%s_out_data[%0d]", tag, k), 64'(od[k]), 64'(0));
            check($sformatf("%s_occupancy[%0d]", tag, k), occ_of(k), 64'(0));
            check($sformatf("%s_busy[%0d]", tag, k), 64'(bz[k]), 64'(0));
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; a[k] = '0; b[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Largest unsigned square, held until popped
        ordy[0] = 1'b0;
        offer(0, 15'h7FFF, 15'h7FFF);
        repeat (4) @(posedge clk);
        #1;
        check("max_square", 64'(od[0]), 64'h3FFF0001);
        check("max_square_occ", occ_of(0), 64'(1));
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;

        // Signed boundary stream
        popped[1].delete();
        ordy[1] = 1'b1;
        offer(1, 15'h7FFF, 15'h0001);
        offer(1, 15'h4000, 15'h4000);
        offer(1, 15'h4000, 15'h3FFF);
        wait_pops(1, 3);
        if (popped[1].size() == 3) begin
            check("signed_0", 64'(popped[1][0]), 64'h3FFFFFFF);
            check("signed_1", 64'(popped[1][1]), 64'h10000000);
            check("signed_2", 64'(popped[1][2]), 64'h30004000);
        end

        // Backpressure: two lanes fill, third pair waits for one pop
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a[0] = pick();
            b[0] = pick();
            @(posedge clk);
            #1;
        end
        check("full_occ", occ_of(0), 64'(2));
        check("full_in_ready", 64'(ir[0]), 64'(0));
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        check("after_pop_in_ready", 64'(ir[0]), 64'(1));
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Synchronous clear with two results pending
        ordy[0] = 1'b0;
        offer(0, pick(), pick());
        offer(0, pick(), pick());
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_occ", occ_of(0), 64'(0));
        check("clr_out_valid", 64'(ov[0]), 64'(0));
        popped[0].delete();
        ordy[0] = 1'b1;
        offer(0, 15'd5, 15'd7);
        wait_pops(0, 1);
        if (popped[0].size() >= 1) check("clr_first_out", 64'(popped[0][0]), 64'd35);

        // Asynchronous reset mid-operation
        ordy[0] = 1'b0;
        offer(0, pick(), pick());
        offer(0, pick(), pick());
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        for (int k = 0; k < 2; k++) begin
            sb[k].delete();
            popped[k].delete();
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        offer(0, 15'd3, 15'd9);
        wait_pops(0, 1);
        if (popped[0].size() >= 1) check("rst_first_out", 64'(popped[0][0]), 64'd27);

        // Continuous streaming on both instances
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k] = 1'b1; ordy[k] = 1'b1; a[k] = pick(); b[k] = pick();
            end
            @(posedge clk);
            #1;
        end

        // Random traffic with occasional clear
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 3) != 0);
                a[k]    = pick();
                b[k]    = pick();
            end
            clr = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
        end

        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1;
        end
        repeat (12) @(posedge clk);
        #1;
        check("drained_u", occ_of(0), 64'(0));
        check("drained_s", occ_of(1), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
